// File: rtl/alu_reservation_station_if.sv
// Decode-side, completion-broadcast and issue-side signals of the ALU reservation station.
// The station itself connects through the slave modport; the producer/consumer side uses master.
interface alu_reservation_station_if #(
  parameter int unsigned TAG_W = 6
) ();
  logic             flash;
  logic             in_en;
  logic             in_reject;
  logic [7:0]       in_commit_id;
  logic [1:0]       in_aux_op;
  logic [2:0]       in_funct3;
  logic [7:0]       in_dest_logic;
  logic [TAG_W-1:0] in_dest_phys;
  logic             in_src1_valid;
  logic [31:0]      in_src1_data;
  logic             in_src2_valid;
  logic [31:0]      in_src2_data;
  logic             cmpl_en;
  logic             cmpl_kind;
  logic [TAG_W-1:0] cmpl_dest_phys;
  logic [31:0]      cmpl_data;
  logic             out_en;
  logic             out_reject;
  logic [7:0]       out_commit_id;
  logic [1:0]       out_aux_op;
  logic [2:0]       out_funct3;
  logic [7:0]       out_dest_logic;
  logic [TAG_W-1:0] out_dest_phys;
  logic [31:0]      out_src1;
  logic [31:0]      out_src2;

  modport master (
    output flash, in_en, in_commit_id, in_aux_op, in_funct3, in_dest_logic, in_dest_phys,
           in_src1_valid, in_src1_data, in_src2_valid, in_src2_data,
           cmpl_en, cmpl_kind, cmpl_dest_phys, cmpl_data, out_reject,
    input  in_reject, out_en, out_commit_id, out_aux_op, out_funct3, out_dest_logic,
           out_dest_phys, out_src1, out_src2
  );

  modport slave (
    input  flash, in_en, in_commit_id, in_aux_op, in_funct3, in_dest_logic, in_dest_phys,
           in_src1_valid, in_src1_data, in_src2_valid, in_src2_data,
           cmpl_en, cmpl_kind, cmpl_dest_phys, cmpl_data, out_reject,
    output in_reject, out_en, out_commit_id, out_aux_op, out_funct3, out_dest_logic,
           out_dest_phys, out_src1, out_src2
  );
endinterface

// File: rtl/alu_reservation_station.sv
// Compacting reservation station: holds decoded ALU ops until both operands are captured,
// then issues the oldest ready op into a registered output slot that absorbs ALU backpressure.
module alu_reservation_station #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 6
) (
  input logic                      clock,
  input logic                      reset,
  alu_reservation_station_if.slave bus
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0]       commit_id;
    logic [1:0]       aux_op;
    logic [2:0]       funct3;
    logic [7:0]       dest_logic;
    logic [TAG_W-1:0] dest_phys;
    logic             src1_valid;
    logic [31:0]      src1_data;
    logic             src2_valid;
    logic [31:0]      src2_data;
  } entry_t;

  typedef struct packed {
    logic [7:0]       commit_id;
    logic [1:0]       aux_op;
    logic [2:0]       funct3;
    logic [7:0]       dest_logic;
    logic [TAG_W-1:0] dest_phys;
    logic [31:0]      src1;
    logic [31:0]      src2;
  } out_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          woken [DEPTH+1];
  entry_t          raw_in;
  entry_t          in_entry;
  logic [CntW-1:0] count_q, count_d;
  logic            out_en_q, out_en_d;
  out_t            out_q, out_d;

  logic [DEPTH-1:0] ready;
  logic             any_ready;
  int unsigned      sel_idx;
  int unsigned      cnt_after;
  logic             cmpl_wb;
  logic             can_load;
  logic             do_issue;
  logic             accept;

  function automatic entry_t wake(entry_t e, logic hit_en, logic [TAG_W-1:0] tag,
                                  logic [31:0] data);
    entry_t r;
    r = e;
    if (hit_en && !r.src1_valid && (r.src1_data[TAG_W-1:0] == tag)) begin
      r.src1_valid = 1'b1;
      r.src1_data  = data;
    end
    if (hit_en && !r.src2_valid && (r.src2_data[TAG_W-1:0] == tag)) begin
      r.src2_valid = 1'b1;
      r.src2_data  = data;
    end
    return r;
  endfunction

  assign cmpl_wb       = bus.cmpl_en & ~bus.cmpl_kind;
  // Full is judged on registered count only, so an issue this cycle never frees a slot early.
  assign bus.in_reject = (count_q == CntW'(DEPTH));
  assign can_load      = ~out_en_q | ~bus.out_reject;
  assign accept        = bus.in_en & ~bus.in_reject & ~bus.flash;
  assign do_issue      = can_load & any_ready & ~bus.flash;

  assign raw_in = '{
    commit_id:  bus.in_commit_id,
    aux_op:     bus.in_aux_op,
    funct3:     bus.in_funct3,
    dest_logic: bus.in_dest_logic,
    dest_phys:  bus.in_dest_phys,
    src1_valid: bus.in_src1_valid,
    src1_data:  bus.in_src1_data,
    src2_valid: bus.in_src2_valid,
    src2_data:  bus.in_src2_data
  };

  always_comb begin
    ready     = '0;
    any_ready = 1'b0;
    sel_idx   = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = (i < 32'(count_q)) && ent_q[i].src1_valid && ent_q[i].src2_valid;
      if (ready[i] && !any_ready) begin
        any_ready = 1'b1;
        sel_idx   = i;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woken[i] = wake(ent_q[i], cmpl_wb, bus.cmpl_dest_phys, bus.cmpl_data);
    end
    woken[DEPTH] = '0;
    in_entry     = wake(raw_in, cmpl_wb, bus.cmpl_dest_phys, bus.cmpl_data);
  end

  always_comb begin
    cnt_after = 32'(count_q) - (do_issue ? 32'd1 : 32'd0);
    count_d   = count_q;
    out_en_d  = out_en_q;
    out_d     = out_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_d[i] = (do_issue && (i >= sel_idx)) ? woken[i+1] : woken[i];
      if (accept && (i == cnt_after)) begin
        ent_d[i] = in_entry;
      end
      // Output loads from pre-wakeup state; a selected entry is already fully valid.
      if (do_issue && (i == sel_idx)) begin
        out_d = '{
          commit_id:  ent_q[i].commit_id,
          aux_op:     ent_q[i].aux_op,
          funct3:     ent_q[i].funct3,
          dest_logic: ent_q[i].dest_logic,
          dest_phys:  ent_q[i].dest_phys,
          src1:       ent_q[i].src1_data,
          src2:       ent_q[i].src2_data
        };
      end
    end
    if (do_issue) begin
      count_d = count_d - CntW'(1);
    end
    if (accept) begin
      count_d = count_d + CntW'(1);
    end
    if (can_load) begin
      out_en_d = do_issue;
    end
    if (bus.flash) begin
      count_d  = '0;
      out_en_d = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      out_en_q <= 1'b0;
      out_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      out_en_q <= out_en_d;
      out_q    <= out_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign bus.out_en         = out_en_q;
  assign bus.out_commit_id  = out_q.commit_id;
  assign bus.out_aux_op     = out_q.aux_op;
  assign bus.out_funct3     = out_q.funct3;
  assign bus.out_dest_logic = out_q.dest_logic;
  assign bus.out_dest_phys  = out_q.dest_phys;
  assign bus.out_src1       = out_q.src1;
  assign bus.out_src2       = out_q.src2;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: a queue-level reference model predicts every issued op
// into a scoreboard; a negedge monitor compares each new presentation of the output slot.
module tb_alu_reservation_station;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 6;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  alu_reservation_station_if #(.TAG_W(TAG_W)) bus ();

  alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]       cid;
    logic [1:0]       aux;
    logic [2:0]       f3;
    logic [7:0]       dl;
    logic [TAG_W-1:0] dp;
    bit               v1;
    logic [31:0]      d1;
    bit               v2;
    logic [31:0]      d2;
  } minst_t;

  minst_t mq[$];
  minst_t exp_q[$];
  minst_t cur_exp;
  bit     m_out_en;
  int     n_checks = 0;
  int     n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic minst_t snoop(minst_t e, logic en, logic kind, logic [TAG_W-1:0] tag,
                                   logic [31:0] val);
    minst_t r;
    r = e;
    if (en && !kind) begin
      if (!r.v1 && r.d1[TAG_W-1:0] == tag) begin r.v1 = 1'b1; r.d1 = val; end
      if (!r.v2 && r.d2[TAG_W-1:0] == tag) begin r.v2 = 1'b1; r.d2 = val; end
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_vec(minst_t e);
    return 128'({e.cid, e.aux, e.f3, e.dl, e.dp, e.d1, e.d2});
  endfunction

  function automatic logic [127:0] act_vec();
    return 128'({bus.out_commit_id, bus.out_aux_op, bus.out_funct3, bus.out_dest_logic,
                 bus.out_dest_phys, bus.out_src1, bus.out_src2});
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_out_en = 1'b0;
  endtask

  // Reference model: spec rules applied to a plain queue, oldest at index 0.
  initial forever begin
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else if (bus.flash) begin
      mq.delete();
      m_out_en = 1'b0;
    end else begin
      automatic bit     full = (mq.size() == DEPTH);
      automatic int     pick = -1;
      automatic minst_t ni;
      foreach (mq[i]) if (pick < 0 && mq[i].v1 && mq[i].v2) pick = i;
      if (!m_out_en || !bus.out_reject) begin
        if (pick >= 0) begin
          exp_q.push_back(mq[pick]);
          mq.delete(pick);
          m_out_en = 1'b1;
        end else begin
          m_out_en = 1'b0;
        end
      end
      foreach (mq[i]) mq[i] = snoop(mq[i], bus.cmpl_en, bus.cmpl_kind, bus.cmpl_dest_phys,
                                    bus.cmpl_data);
      if (bus.in_en && !full) begin
        ni.cid = bus.in_commit_id;   ni.aux = bus.in_aux_op;  ni.f3 = bus.in_funct3;
        ni.dl  = bus.in_dest_logic;  ni.dp  = bus.in_dest_phys;
        ni.v1  = bus.in_src1_valid;  ni.d1  = bus.in_src1_data;
        ni.v2  = bus.in_src2_valid;  ni.d2  = bus.in_src2_data;
        mq.push_back(snoop(ni, bus.cmpl_en, bus.cmpl_kind, bus.cmpl_dest_phys, bus.cmpl_data));
      end
    end
  end

  initial forever begin
    @(posedge reset);
    model_reset();
  end

  // Monitor: each fresh presentation pops one expected op; a held slot must still match it.
  initial begin
    bit prev_held;
    prev_held = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_held = 1'b0;
      end else begin
        chk("out_en", 128'(bus.out_en), 128'(m_out_en));
        chk("in_reject", 128'(bus.in_reject), 128'(mq.size() == DEPTH));
        if (bus.out_en) begin
          if (!prev_held) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_err++;
              $display("FAIL unexpected_issue: got cid %0h expected none at %0t",
                       bus.out_commit_id, $time);
            end else begin
              cur_exp = exp_q.pop_front();
            end
          end
          chk("issue_fields", act_vec(), exp_vec(cur_exp));
        end
        prev_held = bus.out_en && bus.out_reject;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.flash = 1'b0;         bus.in_en = 1'b0;         bus.in_commit_id = '0;
    bus.in_aux_op = '0;       bus.in_funct3 = '0;       bus.in_dest_logic = '0;
    bus.in_dest_phys = '0;    bus.in_src1_valid = 1'b0; bus.in_src1_data = '0;
    bus.in_src2_valid = 1'b0; bus.in_src2_data = '0;    bus.cmpl_en = 1'b0;
    bus.cmpl_kind = 1'b0;     bus.cmpl_dest_phys = '0;  bus.cmpl_data = '0;
    bus.out_reject = 1'b0;
  endtask

  task automatic offer(input logic [7:0] cid, input logic v1, input logic [31:0] d1,
                       input logic v2, input logic [31:0] d2);
    bus.in_en = 1'b1;            bus.in_commit_id = cid;  bus.in_aux_op = cid[1:0];
    bus.in_funct3 = cid[4:2];    bus.in_dest_logic = ~cid; bus.in_dest_phys = cid[TAG_W-1:0];
    bus.in_src1_valid = v1;      bus.in_src1_data = d1;
    bus.in_src2_valid = v2;      bus.in_src2_data = d2;
  endtask

  task automatic bcast(input logic kind, input logic [TAG_W-1:0] tag, input logic [31:0] val);
    bus.cmpl_en = 1'b1;
    bus.cmpl_kind = kind;
    bus.cmpl_dest_phys = tag;
    bus.cmpl_data = val;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_en", 128'(bus.out_en), 128'(0));
    chk("rst_in_reject", 128'(bus.in_reject), 128'(0));
    chk("rst_out_fields", act_vec(), 128'(0));
  endtask

  initial begin
    logic        v1, v2;
    logic [31:0] d1, d2;
    idle();
    reset = 1'b1;
    repeat (2) step();
    chk_reset_state();
    reset = 1'b0;
    step();

    // Single fully valid op: visible two edges after the offer, gone one cycle later.
    offer(8'h05, 1'b1, 32'd7, 1'b1, 32'd9);
    step(); bus.in_en = 1'b0;
    chk("t1_not_yet", 128'(bus.out_en), 128'(0));
    step();
    chk("t1_out_en", 128'(bus.out_en), 128'(1));
    chk("t1_src", 128'({bus.out_src1, bus.out_src2}), 128'({32'd7, 32'd9}));
    step();
    chk("t1_left", 128'(bus.out_en), 128'(0));

    // Tag wakeup; a branch-kind broadcast of the same tag must not wake it.
    offer(8'h06, 1'b0, 32'h0000_0012, 1'b1, 32'd3);
    step(); bus.in_en = 1'b0;
    bcast(1'b1, 6'h12, 32'h1111_1111);
    step();
    bcast(1'b0, 6'h12, 32'hDEAD_BEEF);
    step(); bus.cmpl_en = 1'b0;
    chk("t2_kind_ignored", 128'(bus.out_en), 128'(0));
    step();
    chk("t2_out_en", 128'(bus.out_en), 128'(1));
    chk("t2_src1", 128'(bus.out_src1), 128'(32'hDEAD_BEEF));
    repeat (2) step();

    // Fill with ops waiting on tag 3; fifth offer held until space appears.
    for (int i = 0; i < 4; i++) begin
      offer(8'(i), 1'b0, 32'h5A00_0003 + 32'(i << 8), 1'b1, 32'(i * 10));
      step();
    end
    chk("t3_full", 128'(bus.in_reject), 128'(1));
    offer(8'h04, 1'b1, 32'd100, 1'b1, 32'd200);
    step();
    bcast(1'b0, 6'h03, 32'hABCD_0003);
    step(); bus.cmpl_en = 1'b0;
    chk("t3_still_full", 128'(bus.in_reject), 128'(1));
    step();
    chk("t3_first_cid", 128'(bus.out_commit_id), 128'(0));
    chk("t3_reject_drops", 128'(bus.in_reject), 128'(0));
    step(); bus.in_en = 1'b0;
    repeat (8) step();

    // Younger ready op bypasses an older waiting one.
    offer(8'h10, 1'b0, 32'h0000_0001, 1'b1, 32'd5);
    step();
    offer(8'h11, 1'b1, 32'd11, 1'b1, 32'd12);
    step(); bus.in_en = 1'b0;
    step();
    chk("t4_young_first", 128'({bus.out_en, bus.out_commit_id}), 128'({1'b1, 8'h11}));
    bcast(1'b0, 6'h01, 32'h0000_1234);
    step(); bus.cmpl_en = 1'b0;
    step();
    chk("t4_old_next", 128'({bus.out_en, bus.out_commit_id}), 128'({1'b1, 8'h10}));
    repeat (2) step();

    // Backpressure hold with a full queue behind the slot.
    bus.out_reject = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(8'h20 + 8'(i), 1'b1, 32'(i + 1), 1'b1, 32'(i + 2));
      step();
    end
    bus.in_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t5_hold_cid", 128'({bus.out_en, bus.out_commit_id}), 128'({1'b1, 8'h20}));
      chk("t5_hold_full", 128'(bus.in_reject), 128'(1));
      step();
    end
    bus.out_reject = 1'b0;
    step();
    chk("t5_release", 128'({bus.out_en, bus.out_commit_id}), 128'({1'b1, 8'h21}));
    repeat (6) step();

    // Same-cycle capture on enqueue, then flash with a busy slot and a concurrent offer.
    offer(8'h30, 1'b0, 32'h7700_0015, 1'b1, 32'd1);
    bcast(1'b0, 6'h15, 32'hCAFE_F00D);
    step(); bus.in_en = 1'b0; bus.cmpl_en = 1'b0;
    step();
    chk("t6_capture", 128'({bus.out_en, bus.out_src1}), 128'({1'b1, 32'hCAFE_F00D}));
    step();
    bus.out_reject = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(8'h40 + 8'(i), 1'b1, 32'(i), 1'b1, 32'(i));
      step();
    end
    bus.flash = 1'b1;
    offer(8'h44, 1'b1, 32'd4, 1'b1, 32'd4);
    step();
    idle();
    chk("t6_flash_out_en", 128'(bus.out_en), 128'(0));
    chk("t6_flash_empty", 128'(bus.in_reject), 128'(0));
    repeat (2) step();
    chk("t6_offer_dropped", 128'(bus.out_en), 128'(0));

    // Randomized traffic with one asynchronous reset mid-run.
    for (int n = 0; n < 3000; n++) begin
      bus.flash = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 99) < 60) begin
        v1 = 1'($urandom_range(0, 1));
        v2 = 1'($urandom_range(0, 1));
        d1 = $urandom;
        d2 = $urandom;
        if (!v1) d1[TAG_W-1:0] = TAG_W'($urandom_range(0, 7));
        if (!v2) d2[TAG_W-1:0] = TAG_W'($urandom_range(0, 7));
        offer(8'($urandom), v1, d1, v2, d2);
      end else begin
        bus.in_en = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        bcast($urandom_range(0, 4) == 0, TAG_W'($urandom_range(0, 7)), $urandom);
      end else begin
        bus.cmpl_en = 1'b0;
      end
      bus.out_reject = ($urandom_range(0, 9) < 3);
      if (n == 1500) begin
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state();
        step();
        reset = 1'b0;
      end
      step();
    end

    idle();
    repeat (20) step();
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
